// File: rtl/mcdf_fifo_pkg.sv
// Shared definitions for the MCDF FIFO path: width helper and error-code enum
// (the enum is also decoded by the register block).
package mcdf_fifo_pkg;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_UDF  = 2'd2
  } fifo_err_e;

  // Constant-evaluable ceil(log2(v)); 0 for v <= 1.
  function automatic int unsigned fifo_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_flag_ctrl_if.sv
// Handshake/status bundle between a FIFO channel's control block and its users.
interface fifo_flag_ctrl_if
  import mcdf_fifo_pkg::*;
#(
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = fifo_clog2(DEPTH),
  localparam int CNT_W  = fifo_clog2(DEPTH + 1)
);

  logic              wr_en;
  logic              rd_en;
  logic [CNT_W-1:0]  af_thresh;
  logic [CNT_W-1:0]  ae_thresh;
  logic              err_clr;

  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_ack;
  logic              rd_ack;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  slack;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic              uplink_ready;
  logic              downlink_ready;
  logic              overflow;
  logic              underflow;
  logic [CNT_W-1:0]  high_water;

  // Controller side
  modport slave (
    input  wr_en, rd_en, af_thresh, ae_thresh, err_clr,
    output wr_addr, rd_addr, wr_ack, rd_ack, count, slack,
           full, empty, almost_full, almost_empty,
           uplink_ready, downlink_ready, overflow, underflow, high_water
  );

  // Requester side (uplink/downlink/register block)
  modport master (
    output wr_en, rd_en, af_thresh, ae_thresh, err_clr,
    input  wr_addr, rd_addr, wr_ack, rd_ack, count, slack,
           full, empty, almost_full, almost_empty,
           uplink_ready, downlink_ready, overflow, underflow, high_water
  );

endinterface

// File: rtl/fifo_ptr_wrap.sv
// Modulo-DEPTH incrementing pointer with enable; wraps explicitly so DEPTH
// need not be a power of two.
module fifo_ptr_wrap #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_flag_ctrl.sv
// FIFO control for one MCDF channel: occupancy, RAM addresses, status flags,
// sticky overflow/underflow and high-water tracking.
module fifo_flag_ctrl
  import mcdf_fifo_pkg::*;
#(
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = fifo_clog2(DEPTH),
  localparam int CNT_W  = fifo_clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  fifo_flag_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  high_water_q, high_water_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              full, empty;
  logic              wr_ack, rd_ack;
  fifo_err_e         err_evt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;

  always_comb begin
    full   = (count_q == DEPTH_C);
    empty  = (count_q == '0);
    wr_ack = bus.wr_en && !full;
    rd_ack = bus.rd_en && !empty;

    // full and empty are exclusive (DEPTH >= 2), so at most one error per cycle
    err_evt = ERR_NONE;
    if (bus.wr_en && full)       err_evt = ERR_OVF;
    else if (bus.rd_en && empty) err_evt = ERR_UDF;

    count_d = count_q;
    case ({wr_ack, rd_ack})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A new error in the same cycle as err_clr keeps the flag set
    overflow_d  = (err_evt == ERR_OVF) || (overflow_q  && !bus.err_clr);
    underflow_d = (err_evt == ERR_UDF) || (underflow_q && !bus.err_clr);

    if (bus.err_clr)                  high_water_d = count_d;
    else if (count_d > high_water_q)  high_water_d = count_d;
    else                              high_water_d = high_water_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q      <= '0;
      high_water_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      high_water_q <= high_water_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  fifo_ptr_wrap #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wr_ack),
    .ptr   (wr_ptr)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rd_ack),
    .ptr   (rd_ptr)
  );

  assign bus.wr_addr        = wr_ptr;
  assign bus.rd_addr        = rd_ptr;
  assign bus.wr_ack         = wr_ack;
  assign bus.rd_ack         = rd_ack;
  assign bus.count          = count_q;
  assign bus.slack          = DEPTH_C - count_q;
  assign bus.full           = full;
  assign bus.empty          = empty;
  assign bus.almost_full    = (count_q >= bus.af_thresh);
  assign bus.almost_empty   = (count_q <= bus.ae_thresh);
  assign bus.uplink_ready   = rst_n && !full;
  assign bus.downlink_ready = rst_n && !empty;
  assign bus.overflow       = overflow_q;
  assign bus.underflow      = underflow_q;
  assign bus.high_water     = high_water_q;

endmodule

// File: tb/tb_fifo_flag_ctrl.sv
// Bench for fifo_flag_ctrl: DEPTH=8 instance with a reference model and data
// scoreboard, plus a DEPTH=6 instance for non-power-of-two pointer wrap.
module tb_fifo_flag_ctrl;
  import mcdf_fifo_pkg::*;

  localparam int DA = 8;
  localparam int DB = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_flag_ctrl_if #(.DEPTH(DA)) a_if ();
  fifo_flag_ctrl_if #(.DEPTH(DB)) b_if ();

  fifo_flag_ctrl #(.DEPTH(DA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  fifo_flag_ctrl #(.DEPTH(DB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));

  int n_total = 0;
  int n_bad   = 0;

  // Model state, DEPTH=8 instance
  int m_cnt, m_wp, m_rp, m_hw;
  bit m_ovf, m_udf;
  int af_th, ae_th;
  logic [31:0] mem_a [DA];
  int sb_a [$];
  int data_a = 100;

  // Model state, DEPTH=6 instance
  int b_cnt, b_wp, b_rp;
  logic [31:0] mem_b [DB];
  int sb_b [$];
  int data_b = 500;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    a_if.wr_en = 1'b0; a_if.rd_en = 1'b0; a_if.err_clr = 1'b0;
    b_if.wr_en = 1'b0; b_if.rd_en = 1'b0; b_if.err_clr = 1'b0;
  endtask

  task automatic set_th(input int af, input int ae);
    af_th = af; ae_th = ae;
    a_if.af_thresh = af_th[3:0];
    a_if.ae_thresh = ae_th[3:0];
  endtask

  task automatic check_state_a(input bit in_reset);
    check_val("a_count", a_if.count, m_cnt);
    check_val("a_slack", a_if.slack, DA - m_cnt);
    check_val("a_full", a_if.full, m_cnt == DA);
    check_val("a_empty", a_if.empty, m_cnt == 0);
    check_val("a_almost_full", a_if.almost_full, m_cnt >= af_th);
    check_val("a_almost_empty", a_if.almost_empty, m_cnt <= ae_th);
    check_val("a_uplink_ready", a_if.uplink_ready, !in_reset && m_cnt != DA);
    check_val("a_downlink_ready", a_if.downlink_ready, !in_reset && m_cnt != 0);
    check_val("a_overflow", a_if.overflow, m_ovf);
    check_val("a_underflow", a_if.underflow, m_udf);
    check_val("a_high_water", a_if.high_water, m_hw);
    check_val("a_wr_addr", a_if.wr_addr, m_wp);
    check_val("a_rd_addr", a_if.rd_addr, m_rp);
  endtask

  task automatic reset_models();
    m_cnt = 0; m_wp = 0; m_rp = 0; m_hw = 0; m_ovf = 0; m_udf = 0;
    sb_a.delete();
    b_cnt = 0; b_wp = 0; b_rp = 0;
    sb_b.delete();
  endtask

  // One cycle on the DEPTH=8 instance: combinational acks/addresses and the
  // data scoreboard are checked mid-cycle, registered state after the edge.
  task automatic step_a(input bit we, input bit re, input bit clr);
    bit wa, ra;
    int cnt_n, exp_d;
    idle_inputs();
    a_if.wr_en = we; a_if.rd_en = re; a_if.err_clr = clr;
    @(negedge clk);
    wa = we && (m_cnt != DA);
    ra = re && (m_cnt != 0);
    check_val("a_wr_ack", a_if.wr_ack, wa);
    check_val("a_rd_ack", a_if.rd_ack, ra);
    check_val("a_wr_addr_c", a_if.wr_addr, m_wp);
    check_val("a_rd_addr_c", a_if.rd_addr, m_rp);
    if (ra) begin
      exp_d = (sb_a.size() != 0) ? sb_a.pop_front() : -1;
      check_val("a_data", mem_a[a_if.rd_addr], exp_d);
    end
    if (wa) begin
      mem_a[a_if.wr_addr] = data_a;
      sb_a.push_back(data_a);
      data_a++;
    end
    m_ovf = (we && m_cnt == DA) || (m_ovf && !clr);
    m_udf = (re && m_cnt == 0)  || (m_udf && !clr);
    cnt_n = m_cnt + int'(wa) - int'(ra);
    m_hw  = clr ? cnt_n : ((cnt_n > m_hw) ? cnt_n : m_hw);
    m_cnt = cnt_n;
    if (wa) m_wp = (m_wp + 1) % DA;
    if (ra) m_rp = (m_rp + 1) % DA;
    @(posedge clk); #1;
    idle_inputs();
    check_state_a(1'b0);
  endtask

  task automatic step_b(input bit we, input bit re);
    bit wa, ra;
    int exp_d;
    idle_inputs();
    b_if.wr_en = we; b_if.rd_en = re;
    @(negedge clk);
    wa = we && (b_cnt != DB);
    ra = re && (b_cnt != 0);
    check_val("b_wr_ack", b_if.wr_ack, wa);
    check_val("b_rd_ack", b_if.rd_ack, ra);
    check_val("b_wr_addr", b_if.wr_addr, b_wp);
    check_val("b_rd_addr", b_if.rd_addr, b_rp);
    if (ra) begin
      exp_d = (sb_b.size() != 0) ? sb_b.pop_front() : -1;
      check_val("b_data", mem_b[b_if.rd_addr], exp_d);
    end
    if (wa) begin
      mem_b[b_if.wr_addr] = data_b;
      sb_b.push_back(data_b);
      data_b++;
    end
    b_cnt = b_cnt + int'(wa) - int'(ra);
    if (wa) b_wp = (b_wp + 1) % DB;
    if (ra) b_rp = (b_rp + 1) % DB;
    @(posedge clk); #1;
    idle_inputs();
    check_val("b_count", b_if.count, b_cnt);
    check_val("b_full", b_if.full, b_cnt == DB);
    check_val("b_empty", b_if.empty, b_cnt == 0);
  endtask

  initial begin
    idle_inputs();
    b_if.af_thresh = '0;
    b_if.ae_thresh = '0;
    set_th(6, 2);
    reset_models();

    // Power-on reset
    #12;
    check_state_a(1'b1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_state_a(1'b0);

    // Fill to full, then one illegal write
    repeat (8) step_a(1, 0, 0);
    check_val("fill_full", a_if.full, 1);
    check_val("fill_slack", a_if.slack, 0);
    check_val("fill_wr_addr_wrap", a_if.wr_addr, 0);
    step_a(1, 0, 0);
    check_val("ovf_after_9th", a_if.overflow, 1);
    step_a(0, 0, 1);

    // Both requests at full: only the read goes through
    step_a(1, 1, 0);
    check_val("full_both_count", a_if.count, 7);
    check_val("full_both_ovf", a_if.overflow, 1);
    repeat (7) step_a(0, 1, 0);
    // Both requests at empty: only the write goes through
    step_a(1, 1, 0);
    check_val("empty_both_count", a_if.count, 1);
    check_val("empty_both_udf", a_if.underflow, 1);
    step_a(0, 1, 0);

    // Threshold ramp 0 -> 8 -> 0 (flags checked every cycle in step_a)
    step_a(0, 0, 1);
    repeat (8) step_a(1, 0, 0);
    repeat (8) step_a(0, 1, 0);

    // High-water tracking and error clear
    step_a(0, 0, 1);
    repeat (5) step_a(1, 0, 0);
    repeat (4) step_a(0, 1, 0);
    check_val("hw_peak", a_if.high_water, 5);
    step_a(0, 0, 1);
    check_val("hw_after_clr", a_if.high_water, 1);
    check_val("ovf_after_clr", a_if.overflow, 0);
    check_val("udf_after_clr", a_if.underflow, 0);
    step_a(0, 1, 0);
    step_a(0, 1, 1);
    check_val("udf_set_wins", a_if.underflow, 1);

    // Threshold edge cases at a mid-range count
    repeat (3) step_a(1, 0, 0);
    set_th(0, 15); #1;
    check_val("af_thresh0", a_if.almost_full, 1);
    check_val("ae_thresh15", a_if.almost_empty, 1);
    set_th(8, 8); #1;
    check_val("af_thresh8", a_if.almost_full, 0);
    check_val("ae_thresh8", a_if.almost_empty, 1);
    set_th(4, 3); #1;
    check_val("af_thresh4", a_if.almost_full, 0);
    check_val("ae_thresh3", a_if.almost_empty, 1);
    repeat (3) step_a(0, 1, 0);

    // Non-power-of-two depth: pointers wrap 5 -> 0, order kept
    for (int r = 0; r < 2; r++) begin
      repeat (DB) step_b(1, 0);
      step_b(1, 0);
      repeat (DB) step_b(0, 1);
      step_b(0, 1);
      check_val("b_wr_wrap", b_if.wr_addr, 0);
      check_val("b_rd_wrap", b_if.rd_addr, 0);
    end

    // Random traffic against the model
    for (int i = 0; i < 200; i++) begin
      if ((i % 50) == 0) set_th($urandom_range(0, 9), $urandom_range(0, 9));
      step_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset mid-operation at count 4
    while (m_cnt > 0) step_a(0, 1, 0);
    set_th(6, 2);
    repeat (4) step_a(1, 0, 0);
    check_val("pre_reset_count", a_if.count, 4);
    #2 rst_n = 1'b0;
    #1;
    reset_models();
    check_state_a(1'b1);
    check_val("rst_b_count", b_if.count, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_state_a(1'b0);
    step_a(1, 0, 0);
    step_a(0, 1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
